// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the scratch slave FSM state type.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StData,
    StErr1,
    StErr2
  } state_e;

endpackage

// File: rtl/ahb_lite_scratch_slave_if.sv
// AHB-Lite signal bundle between a master/decoder and the scratch slave.
interface ahb_lite_scratch_slave_if;
  logic        hsel;
  logic        hready;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic        hwrite;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic [1:0]  hresp;
  logic        hready_out;

  modport master (
    output hsel, hready, htrans, hsize, hburst, hwrite, haddr, hwdata,
    input  hrdata, hresp, hready_out
  );

  modport slave (
    input  hsel, hready, htrans, hsize, hburst, hwrite, haddr, hwdata,
    output hrdata, hresp, hready_out
  );
endinterface

// File: rtl/ahb_wstrb_gen.sv
// Byte-lane strobe and alignment check for a little-endian 32-bit AHB beat.
module ahb_wstrb_gen
  import ahb_pkg::*;
(
  input  logic [2:0] size,
  input  logic [1:0] addr_lo,
  output logic [3:0] strb,
  output logic       align_err
);

  always_comb begin
    strb      = 4'b0000;
    align_err = 1'b0;
    case (size)
      HSIZE_BYTE: strb = 4'b0001 << addr_lo;
      HSIZE_HALF: begin
        strb      = addr_lo[1] ? 4'b1100 : 4'b0011;
        align_err = addr_lo[0];
      end
      HSIZE_WORD: begin
        strb      = 4'b1111;
        align_err = (addr_lo != 2'b00);
      end
      default: align_err = 1'b1;  // sizes above a word are unsupported
    endcase
  end

endmodule

// File: rtl/ahb_lite_scratch_slave.sv
// AHB-Lite flop scratchpad with programmable wait states and two-cycle ERROR responses.
module ahb_lite_scratch_slave
  import ahb_pkg::*;
#(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int unsigned ERRCNT_W    = 8
) (
  input  logic                    hclk,
  input  logic                    hrst_n,
  ahb_lite_scratch_slave_if.slave bus,
  output logic [ERRCNT_W-1:0]     err_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);

  state_e        state_q, state_d;
  logic [2:0]    wcnt_q, wcnt_d;
  logic [AW-1:0] idx_q;
  logic          wr_q;
  logic [3:0]    strb_q;
  logic [31:0]   mem_q [DEPTH];

  logic [3:0] strb;
  logic       align_err;
  logic       can_accept;
  logic       accept;
  logic       xfer_err;

  ahb_wstrb_gen u_wstrb_gen (
    .size      (bus.hsize),
    .addr_lo   (bus.haddr[1:0]),
    .strb      (strb),
    .align_err (align_err)
  );

  assign can_accept = (state_q == StIdle) || (state_q == StData) || (state_q == StErr2);
  assign accept     = can_accept & bus.hsel & bus.hready & bus.htrans[1];
  assign xfer_err   = align_err | (bus.haddr[31:AW+2] != '0);

  always_ff @(posedge hclk or negedge hrst_n) begin
    if (!hrst_n) begin
      state_q <= StIdle;
      wcnt_q  <= 3'd0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      strb_q  <= 4'b0000;
      err_cnt <= '0;
      mem_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      if (accept) begin
        idx_q  <= bus.haddr[AW+1:2];
        wr_q   <= bus.hwrite;
        strb_q <= strb;
      end
      if (state_q == StData && wr_q) begin
        for (int b = 0; b < 4; b++) begin
          if (strb_q[b]) mem_q[idx_q][8*b +: 8] <= bus.hwdata[8*b +: 8];
        end
      end
      if (state_q == StErr2 && err_cnt != '1) err_cnt <= err_cnt + ERRCNT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      StWait: begin
        if (wcnt_q == 3'd0) state_d = StData;
        else                wcnt_d  = wcnt_q - 3'd1;
      end
      StErr1: state_d = StErr2;
      default: begin
        // Idle, data and second error cycle all take a pipelined address phase.
        if (!accept) begin
          state_d = StIdle;
        end else if (xfer_err) begin
          state_d = StErr1;
        end else if (WAIT_CYCLES == 0) begin
          state_d = StData;
        end else begin
          state_d = StWait;
          wcnt_d  = 3'(WAIT_CYCLES - 1);
        end
      end
    endcase
  end

  always_comb begin
    bus.hready_out = 1'b1;
    bus.hresp      = HRESP_OKAY;
    bus.hrdata     = 32'h0;
    case (state_q)
      StWait: bus.hready_out = 1'b0;
      StErr1: begin
        bus.hready_out = 1'b0;
        bus.hresp      = HRESP_ERROR;
      end
      StErr2: bus.hresp = HRESP_ERROR;
      StData: if (!wr_q) bus.hrdata = mem_q[idx_q];
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ahb_lite_scratch_slave.sv
// Directed bench: a zero-wait and a three-wait scratch slave sharing one pipelined master.
module tb_ahb_lite_scratch_slave;
  import ahb_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst3;
  logic [7:0] ecnt0, ecnt3;

  ahb_lite_scratch_slave_if b0 ();
  ahb_lite_scratch_slave_if b3 ();

  ahb_lite_scratch_slave #(.DEPTH(16), .WAIT_CYCLES(0), .ERRCNT_W(8)) u_dut0 (
    .hclk    (clk),
    .hrst_n  (rst0),
    .bus     (b0),
    .err_cnt (ecnt0)
  );

  ahb_lite_scratch_slave #(.DEPTH(16), .WAIT_CYCLES(3), .ERRCNT_W(8)) u_dut3 (
    .hclk    (clk),
    .hrst_n  (rst3),
    .bus     (b3),
    .err_cnt (ecnt3)
  );

  logic        use3, hsel0, hsel3, hwrite;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [31:0] haddr, hwdata;
  logic        bus_ready;
  logic [1:0]  bus_resp;
  logic [31:0] bus_rdata;

  assign bus_ready = use3 ? b3.hready_out : b0.hready_out;
  assign bus_resp  = use3 ? b3.hresp : b0.hresp;
  assign bus_rdata = use3 ? b3.hrdata : b0.hrdata;

  assign b0.hsel = hsel0;       assign b3.hsel = hsel3;
  assign b0.hready = bus_ready; assign b3.hready = bus_ready;
  assign b0.htrans = htrans;    assign b3.htrans = htrans;
  assign b0.hsize = hsize;      assign b3.hsize = hsize;
  assign b0.hburst = 3'b000;    assign b3.hburst = 3'b000;
  assign b0.hwrite = hwrite;    assign b3.hwrite = hwrite;
  assign b0.haddr = haddr;      assign b3.haddr = haddr;
  assign b0.hwdata = hwdata;    assign b3.hwdata = hwdata;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Beat list and per-beat results for one pipelined run.
  int          nb = 0;
  logic        bt_sel   [64];
  logic [1:0]  bt_trans [64];
  logic [2:0]  bt_size  [64];
  logic        bt_wr    [64];
  logic [31:0] bt_addr  [64];
  logic [31:0] bt_wdata [64];
  logic [31:0] res_rdata[64];
  logic [1:0]  res_resp [64];
  int          res_wait [64];
  int          res_errc [64];

  task automatic add(input logic sel, input logic [1:0] tr, input logic [2:0] sz,
                     input logic wr, input logic [31:0] a, input logic [31:0] wd);
    bt_sel[nb]   = sel;
    bt_trans[nb] = tr;
    bt_size[nb]  = sz;
    bt_wr[nb]    = wr;
    bt_addr[nb]  = a;
    bt_wdata[nb] = wd;
    res_rdata[nb] = 32'h0;
    res_resp[nb]  = 2'b00;
    res_wait[nb]  = 0;
    res_errc[nb]  = 0;
    nb++;
  endtask

  task automatic drive_addr(input int ai, input int n);
    if (ai < n) begin
      hsel0  = !use3 && bt_sel[ai];
      hsel3  = use3 && bt_sel[ai];
      htrans = bt_trans[ai];
      hsize  = bt_size[ai];
      hwrite = bt_wr[ai];
      haddr  = bt_addr[ai];
    end else begin
      hsel0  = 1'b0;
      hsel3  = 1'b0;
      htrans = HTRANS_IDLE;
      hsize  = HSIZE_WORD;
      hwrite = 1'b0;
      haddr  = 32'h0;
    end
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic run_beats();
    int n, ai, dp, cyc;
    logic rdy;
    logic [1:0] rsp;
    logic [31:0] rd;
    n = nb; ai = 0; dp = -1; cyc = 0;
    drive_addr(ai, n);
    while ((ai < n || dp >= 0) && cyc < 200) begin
      @(negedge clk);
      rdy = bus_ready; rsp = bus_resp; rd = bus_rdata;
      if (dp >= 0) begin
        if (!rdy) res_wait[dp]++;
        if (rsp == HRESP_ERROR) res_errc[dp]++;
      end
      @(posedge clk); #1;
      cyc++;
      if (rdy) begin
        if (dp >= 0) begin
          res_rdata[dp] = rd;
          res_resp[dp]  = rsp;
        end
        dp = (ai < n) ? ai : -1;
        if (ai < n) ai++;
        drive_addr(ai, n);
        hwdata = (dp >= 0) ? bt_wdata[dp] : 32'h0;
      end
    end
    chk("run_budget", (cyc < 200) ? 32'd1 : 32'd0, 32'd1);
    nb = 0;
  endtask

  int          waits;
  logic [1:0]  rsp_or;

  initial begin
    rst0 = 1'b0; rst3 = 1'b0; use3 = 1'b0; hwdata = 32'h0;
    drive_addr(0, 0);
    #12;
    chk("rst_rdy0", {31'b0, b0.hready_out}, 32'd1);
    chk("rst_rdy3", {31'b0, b3.hready_out}, 32'd1);
    chk("rst_resp0", {30'b0, b0.hresp}, 32'd0);
    chk("rst_rdata0", b0.hrdata, 32'h0);
    chk("rst_ecnt0", {24'b0, ecnt0}, 32'd0);
    repeat (2) @(negedge clk);
    rst0 = 1'b1; rst3 = 1'b1;
    @(posedge clk); #1;

    // Fill all 16 words, then read them back pipelined.
    for (int i = 0; i < 16; i++) add(1, HTRANS_NONSEQ, HSIZE_WORD, 1, 32'(4*i), 32'h1111_0000 + 32'(i));
    for (int i = 0; i < 16; i++) add(1, HTRANS_SEQ, HSIZE_WORD, 0, 32'(4*i), 32'h0);
    run_beats();
    waits = 0; rsp_or = 2'b00;
    for (int i = 0; i < 32; i++) begin
      waits += res_wait[i];
      rsp_or |= res_resp[i];
    end
    for (int i = 0; i < 16; i++) chk($sformatf("fill_rd%0d", i), res_rdata[16+i], 32'h1111_0000 + 32'(i));
    chk("fill_waits", 32'(waits), 32'd0);
    chk("fill_resp", {30'b0, rsp_or}, 32'd0);

    // Sub-word lane writes.
    add(1, HTRANS_NONSEQ, HSIZE_BYTE, 1, 32'h5, 32'h5555_AB55);
    add(1, HTRANS_NONSEQ, HSIZE_WORD, 0, 32'h4, 32'h0);
    add(1, HTRANS_NONSEQ, HSIZE_HALF, 1, 32'h6, 32'hBEEF_1234);
    add(1, HTRANS_NONSEQ, HSIZE_WORD, 0, 32'h4, 32'h0);
    run_beats();
    chk("byte_wr", res_rdata[1], 32'h1111_AB01);
    chk("half_wr", res_rdata[3], 32'hBEEF_AB01);

    // Write then read with no gap, then BUSY/IDLE/unselected beats.
    add(1, HTRANS_NONSEQ, HSIZE_WORD, 1, 32'h10, 32'hDEAD_BEEF);
    add(1, HTRANS_NONSEQ, HSIZE_WORD, 0, 32'h10, 32'h0);
    add(1, HTRANS_BUSY,   HSIZE_WORD, 1, 32'h10, 32'h0);
    add(1, HTRANS_IDLE,   HSIZE_WORD, 1, 32'h10, 32'h0);
    add(0, HTRANS_NONSEQ, HSIZE_WORD, 1, 32'h10, 32'h0);
    add(1, HTRANS_NONSEQ, HSIZE_WORD, 0, 32'h10, 32'h0);
    run_beats();
    waits = 0; rsp_or = 2'b00;
    for (int i = 0; i < 6; i++) begin
      waits += res_wait[i];
      rsp_or |= res_resp[i];
    end
    chk("b2b_rd", res_rdata[1], 32'hDEAD_BEEF);
    chk("idle_rd", res_rdata[5], 32'hDEAD_BEEF);
    chk("idle_waits", 32'(waits), 32'd0);
    chk("idle_resp", {30'b0, rsp_or}, 32'd0);

    // Out-of-range write: two-cycle ERROR, no commit.
    add(1, HTRANS_NONSEQ, HSIZE_WORD, 1, 32'h40, 32'h1234_5678);
    add(1, HTRANS_NONSEQ, HSIZE_WORD, 0, 32'h0, 32'h0);
    run_beats();
    chk("oor_errcyc", 32'(res_errc[0]), 32'd2);
    chk("oor_wait", 32'(res_wait[0]), 32'd1);
    chk("oor_resp", {30'b0, res_resp[0]}, {30'b0, HRESP_ERROR});
    chk("oor_mem", res_rdata[1], 32'h1111_0000);
    chk("oor_resp_next", {30'b0, res_resp[1]}, 32'd0);
    chk("oor_ecnt", {24'b0, ecnt0}, 32'd1);

    add(1, HTRANS_NONSEQ, HSIZE_HALF, 1, 32'h1, 32'hFFFF_FFFF);
    add(1, HTRANS_NONSEQ, 3'd3,       0, 32'h0, 32'h0);
    add(1, HTRANS_NONSEQ, HSIZE_WORD, 0, 32'h0, 32'h0);
    run_beats();
    chk("align_resp", {30'b0, res_resp[0]}, {30'b0, HRESP_ERROR});
    chk("size_resp", {30'b0, res_resp[1]}, {30'b0, HRESP_ERROR});
    chk("align_mem", res_rdata[2], 32'h1111_0000);
    chk("align_ecnt", {24'b0, ecnt0}, 32'd3);

    // Three wait states: every OKAY beat stalls exactly three cycles.
    use3 = 1'b1;
    add(1, HTRANS_NONSEQ, HSIZE_WORD, 1, 32'h8, 32'hCAFE_0008);
    add(1, HTRANS_NONSEQ, HSIZE_WORD, 0, 32'h8, 32'h0);
    add(1, HTRANS_NONSEQ, HSIZE_WORD, 0, 32'h8, 32'h0);
    run_beats();
    chk("w3_wr_wait", 32'(res_wait[0]), 32'd3);
    chk("w3_rd_wait", 32'(res_wait[1]), 32'd3);
    chk("w3_rd2_wait", 32'(res_wait[2]), 32'd3);
    chk("w3_rd", res_rdata[1], 32'hCAFE_0008);
    chk("w3_rd2", res_rdata[2], 32'hCAFE_0008);

    // Reset during the wait of a write aborts it.
    hsel3 = 1'b1; htrans = HTRANS_NONSEQ; hsize = HSIZE_WORD; hwrite = 1'b1; haddr = 32'h14;
    @(posedge clk); #1;
    drive_addr(0, 0);
    hwdata = 32'h7777_7777;
    chk("w3_stall", {31'b0, b3.hready_out}, 32'd0);
    @(posedge clk); #1;
    rst3 = 1'b0;
    #1;
    chk("mid_rst_rdy", {31'b0, b3.hready_out}, 32'd1);
    chk("mid_rst_resp", {30'b0, b3.hresp}, 32'd0);
    chk("mid_rst_rdata", b3.hrdata, 32'h0);
    @(negedge clk);
    rst3 = 1'b1;
    hwdata = 32'h0;
    @(posedge clk); #1;
    add(1, HTRANS_NONSEQ, HSIZE_WORD, 0, 32'h14, 32'h0);
    add(1, HTRANS_NONSEQ, HSIZE_WORD, 0, 32'h8, 32'h0);
    run_beats();
    chk("abort_mem", res_rdata[0], 32'h0);
    chk("rst_mem", res_rdata[1], 32'h0);
    chk("rst_ecnt3", {24'b0, ecnt3}, 32'd0);

    // 300 more errors on the zero-wait slave saturate the counter.
    use3 = 1'b0;
    for (int c = 0; c < 5; c++) begin
      for (int i = 0; i < 60; i++) add(1, HTRANS_NONSEQ, 3'd3, 0, 32'h0, 32'h0);
      run_beats();
      if (c == 0) chk("ecnt_63", {24'b0, ecnt0}, 32'd63);
    end
    chk("ecnt_sat", {24'b0, ecnt0}, 32'h0000_00FF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
